// File: rtl/store_merge_unit.sv
// Store merge unit: performs sb/sh/sw; sub-word stores read the aligned word, merge the lane, write it back.
// Latency start->done: word 2 cycles, byte/half MEM_RD_LAT+3 cycles; rejected requests pulse misalign 1 cycle after start.
// No backpressure: start is taken only in IDLE, and a start while busy is dropped without being queued.
module store_merge_unit #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        misalign
);
    localparam int CW = $clog2(MEM_RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE, ERR} stateT;

    stateT         state;
    stateT         nextState;
    logic [31:0]   addrQ;
    logic [15:0]   wdataQ;
    logic [1:0]    sizeQ;
    logic [31:0]   mergeQ;
    logic [31:0]   mergedWord;
    logic [CW-1:0] latCnt;
    logic          reqBad;

    always_comb begin
        reqBad = 1'b0;
        case (size)
            2'b00:   reqBad = (addr[1:0] != 2'b00);
            2'b01:   reqBad = addr[0];
            2'b10:   reqBad = 1'b0;
            default: reqBad = 1'b1;
        endcase
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = reqBad ? ERR : ((size == 2'b00) ? WRITE : READ);
            READ:    if (latCnt == '0) nextState = MERGE;
            MERGE:   nextState = WRITE;
            WRITE:   nextState = DONE;
            DONE:    nextState = IDLE;
            ERR:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Little-endian lane replacement; everything outside the lane keeps the old memory contents.
    always_comb begin
        mergedWord = mem_rdata;
        if (sizeQ == 2'b01) begin
            if (addrQ[1]) mergedWord[31:16] = wdataQ;
            else          mergedWord[15:0]  = wdataQ;
        end else begin
            mergedWord[{addrQ[1:0], 3'b000} +: 8] = wdataQ[7:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= IDLE;
            addrQ  <= '0;
            wdataQ <= '0;
            sizeQ  <= '0;
            mergeQ <= '0;
            latCnt <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (start) begin
                        addrQ  <= addr;
                        wdataQ <= wdata[15:0];
                        sizeQ  <= size;
                        mergeQ <= wdata;
                        latCnt <= CW'(MEM_RD_LAT - 1);
                    end
                end
                READ:    if (latCnt != '0) latCnt <= latCnt - CW'(1);
                MERGE:   mergeQ <= mergedWord;
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign mem_wr    = (state == WRITE);
    assign done      = (state == DONE);
    assign misalign  = (state == ERR);
    assign mem_addr  = busy ? {addrQ[31:2], 2'b00} : '0;
    assign mem_wdata = mem_wr ? mergeQ : '0;
endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: one instance at MEM_RD_LAT=1, one at MEM_RD_LAT=3, shared word memory model.
module tb_store_merge_unit;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        start, start3;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] mem_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata3, mem_addr3, mem_wdata3;
    logic        mem_wr, busy, done, misalign;
    logic        mem_wr3, busy3, done3, misalign3;

    logic [31:0] mem [0:31];
    logic [31:0] pa1;
    logic [31:0] pa3 [0:2];
    int nChecks = 0;
    int nPass = 0;

    always #5 Clk = ~Clk;

    store_merge_unit #(.MEM_RD_LAT(1)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .busy(busy), .done(done), .misalign(misalign)
    );

    store_merge_unit #(.MEM_RD_LAT(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .start(start3), .size(size), .addr(addr), .wdata(wdata),
        .mem_rdata(mem_rdata3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wr(mem_wr3),
        .busy(busy3), .done(done3), .misalign(misalign3)
    );

    // Read data appears MEM_RD_LAT cycles after the address is presented.
    always @(posedge Clk) begin
        pa1    <= mem_addr;
        pa3[0] <= mem_addr3;
        pa3[1] <= pa3[0];
        pa3[2] <= pa3[1];
    end
    assign mem_rdata  = mem[pa1[6:2]];
    assign mem_rdata3 = mem[pa3[2][6:2]];

    // Issues one store and records what the selected instance does over a fixed 20-cycle window.
    task automatic runStore(input bit useSlow, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input int pulseAt,
                            output int doneAt, output int misAt, output int wrAt, output int wrCnt,
                            output logic [31:0] wrAddr, output logic [31:0] wrDat, output int busyCnt);
        doneAt = -1; misAt = -1; wrAt = -1; wrCnt = 0; wrAddr = '0; wrDat = '0; busyCnt = 0;
        @(negedge Clk);
        size = sz; addr = a; wdata = wd;
        start = !useSlow; start3 = useSlow;
        @(negedge Clk);
        for (int c = 1; c <= 20; c++) begin
            start3 = 1'b0;
            if (c == pulseAt) begin
                start = 1'b1; size = 2'b00; addr = 32'h30; wdata = 32'h99999999;
            end else begin
                start = 1'b0; size = 2'($urandom); addr = $urandom; wdata = $urandom;
            end
            if (useSlow ? busy3 : busy) busyCnt++;
            if (useSlow ? mem_wr3 : mem_wr) begin
                wrCnt++;
                wrAt   = c;
                wrAddr = useSlow ? mem_addr3 : mem_addr;
                wrDat  = useSlow ? mem_wdata3 : mem_wdata;
            end
            if ((useSlow ? done3 : done) && doneAt < 0) doneAt = c;
            if ((useSlow ? misalign3 : misalign) && misAt < 0) misAt = c;
            @(negedge Clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; start = 1'b0; start3 = 1'b0; size = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge Clk);
        nChecks++;
        if ({busy, done, misalign, mem_wr, mem_addr, mem_wdata} !== 68'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b mis=%b wr=%b addr=%h wdata=%h want all 0",
                     busy, done, misalign, mem_wr, mem_addr, mem_wdata);
        else nPass++;
        nChecks++;
        if ({busy3, done3, misalign3, mem_wr3, mem_addr3, mem_wdata3} !== 68'd0)
            $display("FAIL reset_outputs_lat3: got busy=%b done=%b mis=%b wr=%b addr=%h wdata=%h want all 0",
                     busy3, done3, misalign3, mem_wr3, mem_addr3, mem_wdata3);
        else nPass++;
        Reset = 1'b1;
    endtask

    task automatic test_word();
        int dA, mA, wA, wC, bC;
        logic [31:0] wAd, wD;
        runStore(1'b0, 2'b00, 32'h10, 32'hDEADBEEF, 0, dA, mA, wA, wC, wAd, wD, bC);
        nChecks++; if (wA !== 1) $display("FAIL word_wr_cycle: got %0d want 1", wA); else nPass++;
        nChecks++; if (wAd !== 32'h10) $display("FAIL word_addr: got %h want 00000010", wAd); else nPass++;
        nChecks++; if (wD !== 32'hDEADBEEF) $display("FAIL word_wdata: got %h want deadbeef", wD); else nPass++;
        nChecks++; if (dA !== 2) $display("FAIL word_done_cycle: got %0d want 2", dA); else nPass++;
        nChecks++; if (bC !== 2) $display("FAIL word_busy_cycles: got %0d want 2", bC); else nPass++;
        nChecks++; if (wC !== 1) $display("FAIL word_wr_count: got %0d want 1", wC); else nPass++;
    endtask

    task automatic test_byte();
        logic [31:0] expW [0:3];
        int dA, mA, wA, wC, bC;
        logic [31:0] wAd, wD;
        expW[0] = 32'h112233AB; expW[1] = 32'h1122AB44; expW[2] = 32'h11AB3344; expW[3] = 32'hAB223344;
        for (int k = 0; k < 4; k++) begin
            runStore(1'b0, 2'b10, 32'h20 + 32'(k), 32'hFFFFFFAB, 0, dA, mA, wA, wC, wAd, wD, bC);
            nChecks++; if (wD !== expW[k]) $display("FAIL byte_wdata off%0d: got %h want %h", k, wD, expW[k]); else nPass++;
            nChecks++; if (wAd !== 32'h20) $display("FAIL byte_addr off%0d: got %h want 00000020", k, wAd); else nPass++;
            nChecks++; if (dA !== 4) $display("FAIL byte_done_cycle off%0d: got %0d want 4", k, dA); else nPass++;
        end
        nChecks++; if (wA !== 3) $display("FAIL byte_wr_cycle: got %0d want 3", wA); else nPass++;
    endtask

    task automatic test_half();
        int dA, mA, wA, wC, bC;
        logic [31:0] wAd, wD;
        runStore(1'b0, 2'b01, 32'h22, 32'h1234CAFE, 0, dA, mA, wA, wC, wAd, wD, bC);
        nChecks++; if (wD !== 32'hCAFE3344) $display("FAIL half_hi_wdata: got %h want cafe3344", wD); else nPass++;
        nChecks++; if (dA !== 4) $display("FAIL half_done_cycle: got %0d want 4", dA); else nPass++;
        runStore(1'b0, 2'b01, 32'h20, 32'h1234CAFE, 0, dA, mA, wA, wC, wAd, wD, bC);
        nChecks++; if (wD !== 32'h1122CAFE) $display("FAIL half_lo_wdata: got %h want 1122cafe", wD); else nPass++;
    endtask

    task automatic test_misalign();
        logic [1:0]  szT [0:2];
        logic [31:0] adT [0:2];
        int dA, mA, wA, wC, bC;
        logic [31:0] wAd, wD;
        szT[0] = 2'b01; adT[0] = 32'h23;
        szT[1] = 2'b00; adT[1] = 32'h12;
        szT[2] = 2'b11; adT[2] = 32'h20;
        for (int v = 0; v < 3; v++) begin
            runStore(1'b0, szT[v], adT[v], 32'h12345678, 0, dA, mA, wA, wC, wAd, wD, bC);
            nChecks++; if (mA !== 1) $display("FAIL mis_cycle v%0d: got %0d want 1", v, mA); else nPass++;
            nChecks++; if (wC !== 0) $display("FAIL mis_wr_count v%0d: got %0d want 0", v, wC); else nPass++;
            nChecks++; if (dA !== -1) $display("FAIL mis_done v%0d: got %0d want -1 (never)", v, dA); else nPass++;
            nChecks++; if (bC !== 1) $display("FAIL mis_busy_cycles v%0d: got %0d want 1", v, bC); else nPass++;
        end
    endtask

    task automatic test_reset_mid();
        int wr = 0;
        @(negedge Clk);
        size = 2'b10; addr = 32'h21; wdata = 32'hAB; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        nChecks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else nPass++;
        Reset = 1'b0;
        @(negedge Clk);
        nChecks++;
        if ({busy, done, misalign, mem_wr, mem_addr, mem_wdata} !== 68'd0)
            $display("FAIL rstmid_outputs: got busy=%b done=%b mis=%b wr=%b addr=%h wdata=%h want all 0",
                     busy, done, misalign, mem_wr, mem_addr, mem_wdata);
        else nPass++;
        Reset = 1'b1;
        repeat (6) begin
            if (mem_wr) wr++;
            @(negedge Clk);
        end
        nChecks++; if (wr !== 0) $display("FAIL rstmid_wr_count: got %0d want 0", wr); else nPass++;
    endtask

    task automatic test_overlap();
        int dA, mA, wA, wC, bC;
        logic [31:0] wAd, wD;
        runStore(1'b0, 2'b10, 32'h22, 32'h000000EE, 2, dA, mA, wA, wC, wAd, wD, bC);
        nChecks++; if (wC !== 1) $display("FAIL overlap_wr_count: got %0d want 1", wC); else nPass++;
        nChecks++; if (wD !== 32'h11EE3344) $display("FAIL overlap_wdata: got %h want 11ee3344", wD); else nPass++;
        nChecks++; if (wAd !== 32'h20) $display("FAIL overlap_addr: got %h want 00000020", wAd); else nPass++;
    endtask

    task automatic test_back_to_back();
        int dA, mA, wA, wC, bC;
        logic [31:0] wAd, wD;
        // start raised during the DONE cycle must be dropped
        runStore(1'b0, 2'b00, 32'h14, 32'h0BADF00D, 2, dA, mA, wA, wC, wAd, wD, bC);
        nChecks++; if (wC !== 1) $display("FAIL b2b_wr_count: got %0d want 1", wC); else nPass++;
        nChecks++; if (bC !== 2) $display("FAIL b2b_busy_cycles: got %0d want 2", bC); else nPass++;
        runStore(1'b0, 2'b00, 32'h18, 32'h01020304, 0, dA, mA, wA, wC, wAd, wD, bC);
        nChecks++; if (wD !== 32'h01020304) $display("FAIL b2b_second_wdata: got %h want 01020304", wD); else nPass++;
    endtask

    task automatic test_slow_read();
        int dA, mA, wA, wC, bC;
        logic [31:0] wAd, wD;
        runStore(1'b1, 2'b10, 32'h41, 32'h00000055, 0, dA, mA, wA, wC, wAd, wD, bC);
        nChecks++; if (wD !== 32'hAABB55DD) $display("FAIL lat3_wdata: got %h want aabb55dd", wD); else nPass++;
        nChecks++; if (wAd !== 32'h40) $display("FAIL lat3_addr: got %h want 00000040", wAd); else nPass++;
        nChecks++; if (wA !== 5) $display("FAIL lat3_wr_cycle: got %0d want 5", wA); else nPass++;
        nChecks++; if (dA !== 6) $display("FAIL lat3_done_cycle: got %0d want 6", dA); else nPass++;
        nChecks++; if (bC !== 6) $display("FAIL lat3_busy_cycles: got %0d want 6", bC); else nPass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hBAD00000 | 32'(i);
        mem[8]  = 32'h11223344;
        mem[16] = 32'hAABBCCDD;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_reset_mid();
        test_overlap();
        test_back_to_back();
        test_slow_read();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
